// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Serializes the datapath's instruction-fetch port (A, read-only) and data
// port (B, read/write with byte mask) onto one physical memory port. Each
// transaction is fully registered: the grant is taken in IDLE, the pmem_*
// request is held through BUSY_x until pmem_resp, and the requester sees a
// one-cycle resp_x pulse in RESP_x. Ties are broken round-robin so neither
// port can starve the other.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   read_a            port A read request (level, held until resp_a)
//   address_a         port A address
//   resp_a, rdata_a   port A completion pulse and read data
//   read_b, write_b   port B read / write request (level)
//   address_b         port B address
//   wdata_b, wmask_b  port B write data and byte enables
//   resp_b, rdata_b   port B completion pulse and read data
//   pmem_read         memory read strobe, held until pmem_resp
//   pmem_write        memory write strobe, held until pmem_resp
//   pmem_address      memory address
//   pmem_wdata        memory write data (zero for reads)
//   pmem_wmask        memory byte enables (zero for reads)
//   pmem_resp         memory completion pulse
//   pmem_rdata        memory read data, valid with pmem_resp
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      read_a,
    input  logic [ADDR_WIDTH-1:0]     address_a,
    output logic                      resp_a,
    output logic [DATA_WIDTH-1:0]     rdata_a,

    input  logic                      read_b,
    input  logic                      write_b,
    input  logic [ADDR_WIDTH-1:0]     address_b,
    input  logic [DATA_WIDTH-1:0]     wdata_b,
    input  logic [DATA_WIDTH/8-1:0]   wmask_b,
    output logic                      resp_b,
    output logic [DATA_WIDTH-1:0]     rdata_b,

    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [ADDR_WIDTH-1:0]     pmem_address,
    output logic [DATA_WIDTH-1:0]     pmem_wdata,
    output logic [DATA_WIDTH/8-1:0]   pmem_wmask,
    input  logic                      pmem_resp,
    input  logic [DATA_WIDTH-1:0]     pmem_rdata
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_A,
        BUSY_B,
        RESP_A,
        RESP_B
    } state_t;

    state_t state_reg;

    // 0: port A was granted last, 1: port B was granted last.
    // Resetting to A means B wins the first tie after reset.
    logic last_grant_b_reg;

    logic                  pend_a;
    logic                  pend_b;
    logic                  grant_a;
    logic                  grant_b;
    logic                  grant_write;
    logic [ADDR_WIDTH-1:0] grant_address;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic [MASK_WIDTH-1:0] grant_wmask;

    // -----------------------------------------------------------------------
    // Arbitration decision. Only consumed in IDLE; the requester inputs are
    // ignored in every other state, so a request that changes mid-transaction
    // has no effect on the one already latched into the pmem_* registers.
    // -----------------------------------------------------------------------
    always_comb begin
        pend_a        = read_a;
        pend_b        = read_b | write_b;
        // B wins when it is alone, or on a tie when A was served last.
        grant_b       = pend_b && (!pend_a || !last_grant_b_reg);
        grant_a       = pend_a && !grant_b;
        // read_b and write_b together is a protocol violation; write wins.
        grant_write   = grant_b && write_b;
        grant_address = grant_b ? address_b : address_a;
    end

    // Per-lane gating: reads present an all-zero data word and byte mask.
    genvar gi;
    generate
        for (gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
            assign grant_wmask[gi]         = grant_write & wmask_b[gi];
            assign grant_wdata[gi*8 +: 8]  = grant_write ? wdata_b[gi*8 +: 8] : 8'd0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Transaction FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            last_grant_b_reg <= 1'b0;
            resp_a           <= 1'b0;
            resp_b           <= 1'b0;
            rdata_a          <= '0;
            rdata_b          <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            pmem_wmask       <= '0;
        end else begin
            // Response pulses last exactly one cycle (the RESP_x state).
            resp_a <= 1'b0;
            resp_b <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // pmem_resp is deliberately not looked at here: a
                    // response with nothing in flight is spurious.
                    if (grant_a || grant_b) begin
                        pmem_read        <= !grant_write;
                        pmem_write       <= grant_write;
                        pmem_address     <= grant_address;
                        pmem_wdata       <= grant_wdata;
                        pmem_wmask       <= grant_wmask;
                        last_grant_b_reg <= grant_b;
                        state_reg        <= grant_b ? BUSY_B : BUSY_A;
                    end
                end

                BUSY_A: begin
                    if (pmem_resp) begin
                        rdata_a    <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        resp_a     <= 1'b1;
                        state_reg  <= RESP_A;
                    end
                end

                BUSY_B: begin
                    // Writes capture too; the value is meaningless but
                    // keeping one path avoids an op-dependent enable.
                    if (pmem_resp) begin
                        rdata_b    <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        resp_b     <= 1'b1;
                        state_reg  <= RESP_B;
                    end
                end

                // The IDLE cycle that follows is always a fresh arbitration,
                // so a requester that drops on seeing resp is not re-granted.
                RESP_A:  state_reg <= IDLE;
                RESP_B:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Simulation checks.
    // -----------------------------------------------------------------------
    // Port B must never ask for a read and a write in the same sampled cycle.
    assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == IDLE) |-> !(read_b && write_b));

    // The memory strobes only exist while a transaction is in BUSY_x.
    assert property (@(posedge clk) disable iff (!rst_n)
        (pmem_read || pmem_write) |-> (state_reg == BUSY_A || state_reg == BUSY_B));

    // Only one requester completes at a time, and never while a strobe is up.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_a && resp_b));
    assert property (@(posedge clk) disable iff (!rst_n)
        (resp_a || resp_b) |-> !(pmem_read || pmem_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A simple memory responder answers
// strobes after mem_wait cycles. A transaction-level model predicts, at each
// arbitration point, the full timeline of the resulting transaction (strobe
// window, response cycle, returned data) into a cycle-indexed ring; one
// compare process checks every DUT output against it on every cycle.
// Directed scenarios add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        read_a = 1'b0;
    logic [31:0] address_a = '0;
    logic        resp_a;
    logic [31:0] rdata_a;
    logic        read_b = 1'b0;
    logic        write_b = 1'b0;
    logic [31:0] address_b = '0;
    logic [31:0] wdata_b = '0;
    logic [3:0]  wmask_b = '0;
    logic        resp_b;
    logic [31:0] rdata_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_wmask;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    logic        auto_resp = 1'b0;
    logic        manual_resp = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic [31:0] manual_rdata = '0;

    assign pmem_resp  = auto_resp | manual_resp;
    assign pmem_rdata = manual_resp ? manual_rdata : auto_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_a       (read_a),
        .address_a    (address_a),
        .resp_a       (resp_a),
        .rdata_a      (rdata_a),
        .read_b       (read_b),
        .write_b      (write_b),
        .address_b    (address_b),
        .wdata_b      (wdata_b),
        .wmask_b      (wmask_b),
        .resp_b       (resp_b),
        .rdata_b      (rdata_b),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_wmask   (pmem_wmask),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int mem_wait = 0;
    bit mem_auto = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents seen by the responder.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h60) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    // ---------------- memory responder ----------------
    int wcnt = 0;
    always @(negedge clk) begin
        auto_resp = 1'b0;
        if (!rst_n || !mem_auto || !(pmem_read || pmem_write)) begin
            wcnt = 0;
        end else if (wcnt >= mem_wait) begin
            auto_resp  = 1'b1;
            auto_rdata = mem_data(pmem_address);
            wcnt       = 0;
        end else begin
            wcnt++;
        end
    end

    // ---------------- transaction-level model ----------------
    localparam int N = 256;
    logic        e_rd [N];
    logic        e_wr [N];
    logic        e_ra [N];
    logic        e_rb [N];
    logic [31:0] e_addr [N];
    logic [31:0] e_wdata [N];
    logic [3:0]  e_wmask [N];
    logic [31:0] e_rdat [N];

    int          m_free = 0;
    logic        m_last_b = 1'b0;
    logic [31:0] held_a = '0;
    logic [31:0] held_b = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            e_rd[i] = 0; e_wr[i] = 0; e_ra[i] = 0; e_rb[i] = 0;
            e_addr[i] = '0; e_wdata[i] = '0; e_wmask[i] = '0; e_rdat[i] = '0;
        end
    end

    always @(negedge clk) begin
        int s;
        int k;
        logic pa, pb, gb, wr;
        logic [31:0] a;
        s = cyc % N;
        if (!rst_n) begin
            chk("rst_pmem_read", 32'(pmem_read), 32'd0);
            chk("rst_pmem_write", 32'(pmem_write), 32'd0);
            chk("rst_resp_a", 32'(resp_a), 32'd0);
            chk("rst_resp_b", 32'(resp_b), 32'd0);
            chk("rst_rdata_a", rdata_a, 32'd0);
            chk("rst_rdata_b", rdata_b, 32'd0);
            m_free   = cyc;
            m_last_b = 1'b0;
            held_a   = '0;
            held_b   = '0;
            for (int j = 0; j < 64; j++) begin
                e_rd[(cyc + j) % N] = 0; e_wr[(cyc + j) % N] = 0;
                e_ra[(cyc + j) % N] = 0; e_rb[(cyc + j) % N] = 0;
            end
        end else begin
            if (e_ra[s]) begin
                held_a = e_rdat[s];
                $display("cycle %0d: port A response rdata=%h", cyc, held_a);
            end
            if (e_rb[s]) begin
                held_b = e_rdat[s];
                $display("cycle %0d: port B response rdata=%h", cyc, held_b);
            end
            chk("pmem_read", 32'(pmem_read), 32'(e_rd[s]));
            chk("pmem_write", 32'(pmem_write), 32'(e_wr[s]));
            chk("resp_a", 32'(resp_a), 32'(e_ra[s]));
            chk("resp_b", 32'(resp_b), 32'(e_rb[s]));
            chk("rdata_a", rdata_a, held_a);
            chk("rdata_b", rdata_b, held_b);
            if (e_rd[s] || e_wr[s]) begin
                chk("pmem_address", pmem_address, e_addr[s]);
                chk("pmem_wdata", pmem_wdata, e_wdata[s]);
                chk("pmem_wmask", 32'(pmem_wmask), 32'(e_wmask[s]));
            end
            e_rd[s] = 0; e_wr[s] = 0; e_ra[s] = 0; e_rb[s] = 0;

            // Arbitrate when no transaction is outstanding: serve whoever
            // is waiting; on a tie serve the port that was not served last.
            if (cyc >= m_free) begin
                pa = read_a;
                pb = read_b | write_b;
                if (pa || pb) begin
                    gb = (pa && pb) ? !m_last_b : pb;
                    wr = gb && write_b;
                    a  = gb ? address_b : address_a;
                    k  = mem_wait;
                    for (int j = 1; j <= k + 1; j++) begin
                        e_rd[(cyc + j) % N]    = !wr;
                        e_wr[(cyc + j) % N]    = wr;
                        e_addr[(cyc + j) % N]  = a;
                        e_wdata[(cyc + j) % N] = wr ? wdata_b : 32'd0;
                        e_wmask[(cyc + j) % N] = wr ? wmask_b : 4'd0;
                    end
                    if (gb) e_rb[(cyc + k + 2) % N] = 1;
                    else    e_ra[(cyc + k + 2) % N] = 1;
                    e_rdat[(cyc + k + 2) % N] = mem_data(a);
                    m_free   = cyc + k + 3;
                    m_last_b = gb;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    bit order_q[$];
    int resp_cyc_q[$];

    task automatic set_ports(input int ra, input int na, input int rb, input int nb);
        read_a    = (ra < na);
        address_a = 32'h100 + 32'(ra) * 4;
        if (rb < nb) begin
            read_b  = (rb % 2 == 0);
            write_b = (rb % 2 != 0);
        end else begin
            read_b  = 1'b0;
            write_b = 1'b0;
        end
        address_b = 32'h2000 + 32'(rb) * 4;
        wdata_b   = 32'h5A00_0000 + 32'(rb);
        wmask_b   = 4'(1 << (rb % 4));
    endtask

    // Each port issues its requests back to back, re-requesting in the cycle
    // after each of its responses and dropping after the last one.
    task automatic run_ports(input int na, input int nb);
        int ra, rb, guard;
        ra = 0; rb = 0; guard = 0;
        order_q.delete();
        resp_cyc_q.delete();
        set_ports(ra, na, rb, nb);
        while ((ra < na || rb < nb) && guard < 300) begin
            at_neg();
            if (resp_a) begin ra++; order_q.push_back(1'b0); resp_cyc_q.push_back(cyc); end
            if (resp_b) begin rb++; order_q.push_back(1'b1); resp_cyc_q.push_back(cyc); end
            step();
            guard++;
            set_ports(ra, na, rb, nb);
        end
        if (guard >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_ports_timeout: got %0d/%0d A and %0d/%0d B responses", ra, na, rb, nb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int t0;

        // Reset values.
        repeat (3) step();
        at_neg();
        chk("reset_pmem_address", pmem_address, 32'd0);
        chk("reset_pmem_wdata", pmem_wdata, 32'd0);
        chk("reset_pmem_wmask", 32'(pmem_wmask), 32'd0);
        step();
        rst_n = 1'b1;

        // Fetch only, k=2.
        step();
        mem_auto = 1'b1; mem_wait = 2;
        read_a = 1'b1; address_a = 32'h60;
        for (int i = 1; i <= 3; i++) begin
            step(); at_neg();
            chk("fetch_strobe", 32'(pmem_read), 32'd1);
            chk("fetch_addr", pmem_address, 32'h60);
        end
        step(); at_neg();
        chk("fetch_resp_a", 32'(resp_a), 32'd1);
        chk("fetch_rdata_a", rdata_a, 32'h0000_0013);
        chk("fetch_strobe_off", 32'(pmem_read), 32'd0);
        step();
        read_a = 1'b0;

        // Store only, k=0.
        step();
        mem_wait = 0;
        write_b = 1'b1; address_b = 32'h1004; wdata_b = 32'hDEAD_BEEF; wmask_b = 4'b1100;
        step(); at_neg();
        chk("store_write", 32'(pmem_write), 32'd1);
        chk("store_read", 32'(pmem_read), 32'd0);
        chk("store_addr", pmem_address, 32'h1004);
        chk("store_wdata", pmem_wdata, 32'hDEAD_BEEF);
        chk("store_wmask", 32'(pmem_wmask), 32'hC);
        step(); at_neg();
        chk("store_resp_b", 32'(resp_b), 32'd1);
        chk("store_write_off", 32'(pmem_write), 32'd0);
        step();
        write_b = 1'b0;

        // Spurious pmem_resp in IDLE.
        step();
        mem_auto = 1'b0;
        manual_rdata = 32'hFFFF_FFFF; manual_resp = 1'b1;
        step();
        manual_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("spur_resp_a", 32'(resp_a), 32'd0);
            chk("spur_resp_b", 32'(resp_b), 32'd0);
            chk("spur_rdata_a", rdata_a, 32'h0000_0013);
            chk("spur_rdata_b", rdata_b, 32'hA5A5_1004);
            step();
        end

        // Reset in the middle of a pending write.
        mem_wait = 5;
        write_b = 1'b1; address_b = 32'h2040; wdata_b = 32'h1234_5678; wmask_b = 4'hF;
        step(); at_neg();
        chk("rbusy_write", 32'(pmem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pmem_write", 32'(pmem_write), 32'd0);
        chk("arst_pmem_address", pmem_address, 32'd0);
        chk("arst_pmem_wdata", pmem_wdata, 32'd0);
        chk("arst_pmem_wmask", 32'(pmem_wmask), 32'd0);
        chk("arst_rdata_a", rdata_a, 32'd0);
        chk("arst_rdata_b", rdata_b, 32'd0);
        write_b = 1'b0;
        step(); step();
        rst_n = 1'b1;
        manual_rdata = 32'hCAFE_F00D; manual_resp = 1'b1;
        step();
        manual_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("post_rst_resp_a", 32'(resp_a), 32'd0);
            chk("post_rst_resp_b", 32'(resp_b), 32'd0);
            chk("post_rst_rdata_b", rdata_b, 32'd0);
            step();
        end

        // Simultaneous first requests after reset: B first, then A.
        do_reset();
        mem_auto = 1'b1; mem_wait = 0;
        step();
        t0 = cyc;
        run_ports(1, 1);
        chk("sim_count", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            chk("sim_first_is_b", 32'(order_q[0]), 32'd1);
            chk("sim_second_is_a", 32'(order_q[1]), 32'd0);
            chk("sim_resp_b_cycle", 32'(resp_cyc_q[0] - t0), 32'd2);
            chk("sim_resp_a_cycle", 32'(resp_cyc_q[1] - t0), 32'd5);
        end

        // Fairness: both ports keep re-requesting, k=1.
        do_reset();
        mem_wait = 1;
        step();
        t0 = cyc;
        run_ports(4, 4);
        chk("fair_count", 32'(order_q.size()), 32'd8);
        if (order_q.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk("fair_order", 32'(order_q[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("fair_first_cycle", 32'(resp_cyc_q[0] - t0), 32'd3);
            chk("fair_last_cycle", 32'(resp_cyc_q[7] - t0), 32'd31);
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
